// File: rtl/vga_layer_compositor.sv
// Fixed-priority overlay compositor between vga_sync and the RGB pins.
// Registers colour with delayed syncs, runs frame blink and a per-frame collision flag.
module vga_layer_compositor #(
  parameter int unsigned NUM_LAYERS   = 9,
  parameter int unsigned RGB_W        = 3,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_tick,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       blink_mask,
  input  logic [RGB_W-1:0]            bg_rgb,
  output logic                        hsync,
  output logic                        vsync,
  output logic [RGB_W-1:0]            rgb,
  output logic                        blink_phase,
  output logic                        collision
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]      blink_cnt;
  logic                  coll_acc;
  logic [NUM_LAYERS-1:0] vis;
  logic [RGB_W-1:0]      win_rgb;
  logic [RGB_W-1:0]      next_rgb;
  logic                  found;
  logic                  multi;
  logic                  collides;
  logic                  frame_tick;

  assign frame_tick = pixel_tick && (pixel_x == '0) && (pixel_y == '0);
  assign vis = layer_on & layer_en & ~(blink_mask & {NUM_LAYERS{blink_phase}});

  // Ascending scan: the first visible layer claims the pixel, any later hit marks a collision.
  always_comb begin
    found   = 1'b0;
    multi   = 1'b0;
    win_rgb = bg_rgb;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (vis[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          win_rgb = layer_rgb[i*RGB_W +: RGB_W];
          found   = 1'b1;
        end
      end
    end
    next_rgb = video_on ? win_rgb : '0;
    collides = video_on & multi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (pixel_tick) begin
      rgb   <= next_rgb;
      hsync <= hsync_in;
      vsync <= vsync_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // The frame-tick pixel belongs to the new frame, so it seeds the accumulator rather than the report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_acc  <= 1'b0;
      collision <= 1'b0;
    end else if (frame_tick) begin
      collision <= coll_acc;
      coll_acc  <= collides;
    end else if (pixel_tick) begin
      coll_acc  <= coll_acc | collides;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor with two-frame blink period.
module tb_vga_layer_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_tick;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [8:0]  layer_on;
  logic [26:0] layer_rgb;
  logic [8:0]  layer_en;
  logic [8:0]  blink_mask;
  logic [2:0]  bg_rgb;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        blink_phase;
  logic        collision;

  int total = 0;
  int bad   = 0;

  vga_layer_compositor #(
    .NUM_LAYERS  (9),
    .RGB_W       (3),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick),
    .video_on   (video_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .layer_on   (layer_on),
    .layer_rgb  (layer_rgb),
    .layer_en   (layer_en),
    .blink_mask (blink_mask),
    .bg_rgb     (bg_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .blink_phase(blink_phase),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pos();
    pixel_x = 10'd0;
    pixel_y = 10'd0;
  endtask

  task automatic mid_pos();
    pixel_x = 10'd5;
    pixel_y = 10'd5;
  endtask

  initial begin
    // layer 0=001, 1=100, 2=010, 3=011, 4=101, 5..8=110
    layer_rgb  = {3'b110, 3'b110, 3'b110, 3'b110, 3'b101, 3'b011, 3'b010, 3'b100, 3'b001};
    reset      = 1'b1;
    pixel_tick = 1'b1;
    video_on   = 1'b1;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    layer_on   = 9'h000;
    layer_en   = 9'h1ff;
    blink_mask = 9'h000;
    bg_rgb     = 3'b111;
    mid_pos();
    step();
    step();
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_hsync", 32'(hsync), 32'h0);
    check("rst_vsync", 32'(vsync), 32'h0);
    check("rst_phase", 32'(blink_phase), 32'h0);
    check("rst_coll", 32'(collision), 32'h0);
    reset = 1'b0;

    // T1: count 0->1
    frame_pos();
    step();
    check("t1_rgb_bg", 32'(rgb), 32'h7);
    check("t1_coll", 32'(collision), 32'h0);
    check("t1_phase", 32'(blink_phase), 32'h0);

    mid_pos();
    layer_on = 9'h006;
    step();
    check("prio_l1", 32'(rgb), 32'h4);
    layer_en = 9'h1fd;
    step();
    check("prio_l2", 32'(rgb), 32'h2);
    layer_on = 9'h000;
    step();
    check("prio_bg", 32'(rgb), 32'h7);
    layer_en = 9'h000;
    layer_on = 9'h1ff;
    step();
    check("en_zero_bg", 32'(rgb), 32'h7);
    layer_en = 9'h1ff;
    video_on = 1'b0;
    step();
    check("blank", 32'(rgb), 32'h0);

    video_on = 1'b1;
    layer_on = 9'h002;
    hsync_in = 1'b1;
    step();
    check("hs_hi", 32'(hsync), 32'h1);
    check("hs_rgb", 32'(rgb), 32'h4);
    check("hs_vs", 32'(vsync), 32'h0);
    hsync_in = 1'b0;
    vsync_in = 1'b1;
    layer_on = 9'h004;
    step();
    check("hs_lo", 32'(hsync), 32'h0);
    check("vs_hi", 32'(vsync), 32'h1);
    check("vs_rgb", 32'(rgb), 32'h2);
    vsync_in = 1'b0;
    layer_on = 9'h000;
    step();
    check("vs_lo", 32'(vsync), 32'h0);
    check("vs_lo_rgb", 32'(rgb), 32'h7);

    // Gated: nothing may move, including a would-be frame tick.
    pixel_tick = 1'b0;
    frame_pos();
    layer_on = 9'h001;
    bg_rgb   = 3'b000;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("gate_rgb", 32'(rgb), 32'h7);
    end
    check("gate_hs", 32'(hsync), 32'h0);
    check("gate_vs", 32'(vsync), 32'h0);
    check("gate_phase", 32'(blink_phase), 32'h0);
    check("gate_coll", 32'(collision), 32'h0);
    pixel_tick = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    layer_on = 9'h000;
    bg_rgb   = 3'b111;

    // T2: reports the layer 1+2 overlap, phase -> 1
    step();
    check("t2_coll", 32'(collision), 32'h1);
    check("t2_phase", 32'(blink_phase), 32'h1);
    check("t2_rgb", 32'(rgb), 32'h7);

    mid_pos();
    blink_mask = 9'h001;
    layer_on   = 9'h001;
    step();
    check("blink_hidden", 32'(rgb), 32'h7);
    layer_on = 9'h018;
    video_on = 1'b0;
    step();
    check("ovl_blank_rgb", 32'(rgb), 32'h0);
    video_on = 1'b1;
    layer_on = 9'h001;

    // T3: count 0->1, still hidden
    frame_pos();
    step();
    check("t3_rgb", 32'(rgb), 32'h7);
    check("t3_coll", 32'(collision), 32'h0);
    check("t3_phase", 32'(blink_phase), 32'h1);
    mid_pos();
    step();
    check("t3_mid_rgb", 32'(rgb), 32'h7);

    // T4: tick pixel still uses old phase, then phase -> 0
    frame_pos();
    step();
    check("t4_old_phase", 32'(rgb), 32'h7);
    check("t4_phase", 32'(blink_phase), 32'h0);
    mid_pos();
    step();
    check("t4_shown", 32'(rgb), 32'h1);
    layer_on = 9'h018;
    step();
    check("l3_l4_rgb", 32'(rgb), 32'h3);
    layer_on = 9'h001;

    frame_pos();
    step();
    check("t5_rgb", 32'(rgb), 32'h1);
    check("t5_coll", 32'(collision), 32'h1);
    check("t5_phase", 32'(blink_phase), 32'h0);
    layer_on = 9'h000;
    step();
    check("t6_coll", 32'(collision), 32'h0);
    check("t6_phase", 32'(blink_phase), 32'h1);

    // Arrange phase=1, collision=1 before resetting mid-frame.
    mid_pos();
    layer_on = 9'h018;
    step();
    layer_on = 9'h000;
    frame_pos();
    step();
    check("t7_coll", 32'(collision), 32'h1);
    check("t7_phase", 32'(blink_phase), 32'h1);
    mid_pos();
    hsync_in = 1'b1;
    step();
    check("pre_rst_rgb", 32'(rgb), 32'h7);
    check("pre_rst_hs", 32'(hsync), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rgb", 32'(rgb), 32'h0);
    check("arst_hs", 32'(hsync), 32'h0);
    check("arst_phase", 32'(blink_phase), 32'h0);
    check("arst_coll", 32'(collision), 32'h0);
    step();
    hsync_in = 1'b0;
    reset = 1'b0;

    frame_pos();
    step();
    check("r1_phase", 32'(blink_phase), 32'h0);
    check("r1_coll", 32'(collision), 32'h0);
    mid_pos();
    layer_on = 9'h018;
    step();
    layer_on = 9'h000;
    frame_pos();
    step();
    check("r2_phase", 32'(blink_phase), 32'h1);
    check("r2_coll", 32'(collision), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
